// File: rtl/pipe_stage_skid.sv
// Generic MIPS inter-stage register with valid/ready handshake and a 2-entry skid buffer.
// Flush turns every held entry into a bubble; all outputs decode from registers only.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 170,
    parameter int unsigned       CTRL_W      = 9,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    logic accept;
    logic drain;
    logic loadMainFromIn;
    logic loadSkidFromIn;
    logic loadMainFromSkid;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    assign loadMainFromIn   = accept & ((state == EMPTY) | ((state == ONE) & drain));
    assign loadSkidFromIn   = accept & (state == ONE) & ~drain;
    assign loadMainFromSkid = (state == TWO) & drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) stateNext = ONE;
                ONE: begin
                    if (accept && !drain)      stateNext = TWO;
                    else if (!accept && drain) stateNext = EMPTY;
                end
                TWO:     if (drain) stateNext = ONE;
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Flush only scrubs control; stale data is harmless once its control is a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= '0;
            mainCtrl <= CTRL_BUBBLE;
            skidData <= '0;
            skidCtrl <= CTRL_BUBBLE;
        end else if (flush) begin
            mainCtrl <= CTRL_BUBBLE;
            skidCtrl <= CTRL_BUBBLE;
        end else begin
            if (loadMainFromIn) begin
                mainData <= in_data;
                mainCtrl <= in_ctrl;
            end else if (loadMainFromSkid) begin
                mainData <= skidData;
                mainCtrl <= skidCtrl;
            end
            if (loadSkidFromIn) begin
                skidData <= in_data;
                skidCtrl <= in_ctrl;
            end
        end
    end

    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        occupancy = 2'(state);
        out_data  = mainData;
        out_ctrl  = (state != EMPTY) ? mainCtrl : CTRL_BUBBLE;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor of the ID/EX pipeline register: a generic inter-stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle, plus a valid/ready handshake.
- A 2-entry skid buffer registers backpressure while keeping full throughput.
- Synchronous flush converts held entries into bubbles whose control field is forced to a safe value, so no writes occur.

Parameters:
DATA_W, 170, width of data bundle (e.g. readData1, readData2, immediate, nextPC, rd, rt, funct).
CTRL_W, 9, width of control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp).
CTRL_BUBBLE, 0, control value emitted and stored for a bubble or flushed entry.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous kill of all held entries and of the current input beat.
in_valid  in  1  upstream beat present.
in_ready  out  1  stage can accept a beat this cycle.
in_data  in  DATA_W  upstream data bundle.
in_ctrl  in  CTRL_W  upstream control bundle.
out_valid  out  1  downstream beat present.
out_ready  in  1  downstream accepts this cycle (0 = stall, e.g. cache miss).
out_data  out  DATA_W  head entry data.
out_ctrl  out  CTRL_W  head entry control; CTRL_BUBBLE when out_valid=0.
occupancy  out  2  entries held, 0..2.

Behaviour:
- Storage: main register (head) and skid register. State is EMPTY (0), ONE (main valid) or TWO (main+skid valid).
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - A beat transfers only on an edge where the handshake is true.
- Output decode:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - occupancy encodes the state.
  - All outputs are decoded from registers only. There is no combinational path in_valid->out_valid or out_ready->in_ready.
- Transitions (flush=0):
  - EMPTY: accept -> ONE, main<=in; otherwise hold.
  - ONE, accept & drain -> ONE, main<=in.
  - ONE, accept & !drain -> TWO, skid<=in.
  - ONE, !accept & drain -> EMPTY.
  - ONE, neither -> hold.
  - TWO: drain -> ONE, main<=skid; otherwise hold. No accept is possible because in_ready=0.
- Flush (highest priority over all events):
  - Next state EMPTY.
  - main_ctrl and skid_ctrl <= CTRL_BUBBLE; data registers hold their values.
  - A beat handshaken in the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed by downstream.
- Ordering: strict FIFO; beats never reorder, duplicate or drop, except by flush.
- Stall: out_ready=0 holds out_data/out_ctrl bit-stable for as long as out_valid=1.
- Reset (asynchronous assert, deassert sampled on clk): state EMPTY, in_ready=1, out_valid=0, occupancy=0, out_data=0, skid data=0, out_ctrl=CTRL_BUBBLE, skid ctrl=CTRL_BUBBLE.
- Reset mid-transfer discards all entries immediately, without waiting for a clock edge.
- Throughput: 1 beat/cycle when out_ready=1 continuously. Latency in->out is 1 cycle.

Test Plan:
- Reset with rst_n=0 asynchronously mid-cycle, with TWO entries held -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0 before the next clk edge.
- Stream 0x01..0x10 with in_valid=1 and out_ready=1 for 16 cycles -> out_data = 0x01..0x10, one per cycle, starting 1 cycle after the first beat; occupancy stays 1.
- Stall: send A=0xA5, B=0x5A, hold out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA5 stable. Release out_ready -> A then B on consecutive cycles, then in_ready=1.
- Flush with TWO entries (ctrl=0x1FF each) while in_valid=1 with C -> next cycle out_valid=0, occupancy=0, out_ctrl=0; C never appears at the output.
- Simultaneous accept & drain in ONE with out_ready=1: data changes from 0x11 to 0x22 -> occupancy remains 1, out_data=0x22 next cycle.
- Random valid/ready toggling (10k cycles, seeded) -> scoreboard shows in-order, lossless delivery, and out_data stable whenever out_valid=1 & out_ready=0.
